weight_rom_sequencer: RTL and testbench
=======================================

// Module: weight_rom_sequencer
// PURPOSE
//  Streams one layer's convolution coefficients from a synchronous coefficient ROM into the downstream ap_fifo weight stream.
//  - Generates ROM addresses 0..KERN_SIZE-1 and repeats them for a run-time number of passes (one pass per output tile).
//  - Absorbs the 1-cycle ROM read latency with a 2-entry skid buffer, so output_V_full_n backpressure never loses a coefficient.
//  - Uses ap_start/ap_done/ap_idle control; sits between the layer controller, the coefficient ROM and the conv engine weight FIFO.
// PARAMETERS
//  KERN_SIZE  288                  coefficients per pass (ROM depth), >=1
//  DATA_W     16                   coefficient width (matches coeff_width)
//  ADDR_W     $clog2(KERN_SIZE)    ROM address width (1 when KERN_SIZE==1)
//  PASS_W     8                    width of pass-count input
// PORTS
//  ap_clk             in   1       clock, all logic rising-edge
//  ap_rst             in   1       asynchronous reset, active-high
//  ap_start           in   1       start request, sampled only in IDLE
//  num_passes         in   PASS_W  pass count, latched on accepted start; 0 treated as 1
//  ap_done            out  1       1-cycle pulse at end of run
//  ap_idle            out  1       high in IDLE
//  weight_address     out  ADDR_W  ROM read address
//  weight_ce          out  1       ROM read enable; q valid exactly 1 cycle later
//  weight_q           in   DATA_W  ROM read data
//  output_V_din       out  DATA_W  coefficient to weight FIFO
//  output_V_full_n    in   1       downstream not full
//  output_V_write     out  1       write strobe; transfer when write && full_n
// BEHAVIOUR
//  - Reset values: FSM=IDLE, ap_idle=1, ap_done=0, weight_ce=0, weight_address=0, output_V_write=0, output_V_din=0, buffer empty, in-flight=0.
//  - FSM states:
//    - IDLE: ap_start=1 -> RUN; clear addr and pass counter; latch passes = max(num_passes,1).
//    - RUN: issue reads per the rule below; after the read of addr KERN_SIZE-1 in the last pass -> DRAIN.
//    - DRAIN: no reads; when buffer empty and in-flight=0 -> DONE.
//    - DONE: ap_done=1 for one cycle -> IDLE. ap_start is ignored outside IDLE.
//  - Read issue (RUN): weight_ce=1 iff occupancy + in-flight + 1 <= 2, with occupancy counted after this cycle's pop.
//  - Address counter:
//    - advances only on issued reads.
//    - At KERN_SIZE-1 it wraps to 0 and increments the pass counter. KERN_SIZE==1 re-reads addr 0 each pass.
//  - Skid buffer: 2-entry FIFO, push on the cycle after each issued read (in-flight bit), data = weight_q.
//    - output_V_write = buffer non-empty. output_V_din = head entry, registered, never combinational from weight_q.
//    - Pop when output_V_write && output_V_full_n.
//    - Push and pop in the same cycle are both honoured; occupancy unchanged.
//    - Order preserved, no drops, no duplicates. Overflow is impossible by the issue rule; assert in simulation.
//  - Output sequence: q[0..K-1] repeated P times, K*P words total.
//  - Throughput: 1 word/cycle sustained while full_n=1. Latency from start accept to first write = 2 cycles.
//  - Backpressure: output_V_din holds stable while write=1 && full_n=0. Reads stall once 2 words are buffered or in flight.
//  - ap_done asserts no earlier than the cycle after the final transfer.
//  - ap_rst mid-run: immediate asynchronous return to reset values; buffered and in-flight words are discarded; the next start restarts at addr 0, pass 0.
// TESTING
//  - K=4, P=2, full_n=1 -> weight_ce on 8 consecutive cycles; din = q0,q1,q2,q3,q0,q1,q2,q3 on consecutive cycles; ap_done 1 cycle after the last write.
//  - K=4, P=1, full_n=0 for cycles 3-7 after start -> <=2 words buffered, din stable, no ce beyond credit; 4 ordered words total after release.
//  - Random full_n (50%), K=288, P=3 -> exactly 864 transfers matching the ROM image in order; scoreboard has no gaps.
//  - num_passes=0, K=4 -> treated as 1 pass: 4 words, then ap_done.
//  - ap_rst asserted mid-pass 1 at addr 100 -> all outputs at reset values the same cycle; restart yields addr 0 first.
//  - ap_start held high through DONE -> a second run starts only from IDLE; ap_idle=1 for >=1 cycle between runs.

Source files
------------

// File: rtl/weight_rom_sequencer.sv
// -----------------------------------------------------------------------------
// weight_rom_sequencer
//
// Purpose:
//   Streams one layer's convolution coefficients from a synchronous coefficient
//   ROM into the downstream ap_fifo weight stream. ROM addresses 0..KERN_SIZE-1
//   are generated and repeated for a run-time number of passes (one pass per
//   output tile). A 2-entry skid buffer absorbs the 1-cycle ROM read latency so
//   that backpressure on the weight FIFO never loses a coefficient.
//
// Ports:
//   ap_clk           in   1       clock, rising edge
//   ap_rst           in   1       asynchronous reset, active-high
//   ap_start         in   1       start request, only looked at in IDLE
//   num_passes       in   PASS_W  pass count, captured on start (0 means 1)
//   ap_done          out  1       one-cycle pulse at end of run
//   ap_idle          out  1       high while idle
//   weight_address   out  ADDR_W  ROM read address
//   weight_ce        out  1       ROM read enable (data returns next cycle)
//   weight_q         in   DATA_W  ROM read data
//   output_V_din     out  DATA_W  coefficient towards the weight FIFO
//   output_V_full_n  in   1       weight FIFO can accept a word
//   output_V_write   out  1       write strobe (transfer = write && full_n)
// -----------------------------------------------------------------------------
module weight_rom_sequencer #(
  parameter int KERN_SIZE = 288,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = (KERN_SIZE > 1) ? $clog2(KERN_SIZE) : 1,
  parameter int PASS_W    = 8
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  input  logic [PASS_W-1:0] num_passes,
  output logic              ap_done,
  output logic              ap_idle,
  output logic [ADDR_W-1:0] weight_address,
  output logic              weight_ce,
  input  logic [DATA_W-1:0] weight_q,
  output logic [DATA_W-1:0] output_V_din,
  input  logic              output_V_full_n,
  output logic              output_V_write
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(KERN_SIZE - 1);

  state_t state_reg;
  state_t state_next;

  // Address / pass bookkeeping
  logic [ADDR_W-1:0] addr_reg;
  logic [PASS_W-1:0] pass_reg;
  logic [PASS_W-1:0] passes_reg;

  // Skid buffer bookkeeping
  logic       inflight_reg;   // a read was issued last cycle, weight_q is valid now
  logic [1:0] count_reg;      // buffered words, 0..2
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;

  logic       push;
  logic       pop;
  logic [1:0] count_after_pop;
  logic [1:0] committed;
  logic [1:0] count_next;
  logic       credit_ok;
  logic       start_accept;
  logic       addr_wrap;
  logic       last_pass;
  logic       last_read;

  // ---------------------------------------------------------------------------
  // Flow-control terms
  // ---------------------------------------------------------------------------
  assign output_V_write  = (count_reg != 2'd0);
  assign pop             = output_V_write && output_V_full_n;
  assign push            = inflight_reg;
  assign count_after_pop = count_reg - {1'b0, pop};
  // Every word already buffered (after this cycle's pop) or still coming back
  // from the ROM holds one of the two buffer slots; a new read needs a free one.
  assign committed       = count_after_pop + {1'b0, inflight_reg};
  assign credit_ok       = (committed <= 2'd1);
  assign count_next      = count_reg + {1'b0, push} - {1'b0, pop};

  assign start_accept    = (state_reg == ST_IDLE) && ap_start;
  assign addr_wrap       = (addr_reg == LAST_ADDR);
  assign last_pass       = (pass_reg == (passes_reg - PASS_W'(1)));
  assign last_read       = weight_ce && addr_wrap && last_pass;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (ap_start) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_read) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave as soon as the final word is being transferred this cycle, so
        // ap_done lands on the cycle right after the last transfer.
        if ((count_next == 2'd0) && !inflight_reg) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ap_idle   = 1'b0;
    ap_done   = 1'b0;
    weight_ce = 1'b0;
    unique case (state_reg)
      ST_IDLE:  ap_idle   = 1'b1;
      ST_RUN:   weight_ce = credit_ok;
      ST_DRAIN: weight_ce = 1'b0;
      ST_DONE:  ap_done   = 1'b1;
      default:  ap_idle   = 1'b0;
    endcase
  end

  assign weight_address = addr_reg;

  // ---------------------------------------------------------------------------
  // Address and pass counters; only issued reads advance them
  // ---------------------------------------------------------------------------
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      addr_reg   <= '0;
      pass_reg   <= '0;
      passes_reg <= PASS_W'(1);
    end else if (start_accept) begin
      addr_reg   <= '0;
      pass_reg   <= '0;
      passes_reg <= (num_passes == '0) ? PASS_W'(1) : num_passes;
    end else if (weight_ce) begin
      if (addr_wrap) begin
        addr_reg <= '0;
        pass_reg <= pass_reg + PASS_W'(1);
      end else begin
        addr_reg <= addr_reg + ADDR_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Skid buffer control: in-flight flag, occupancy and ring pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      inflight_reg <= 1'b0;
      count_reg    <= 2'd0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
    end else begin
      inflight_reg <= weight_ce;
      count_reg    <= count_next;
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Skid buffer storage: one register per slot, written from weight_q
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [DATA_W-1:0] data_reg;
      always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
          data_reg <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          data_reg <= weight_q;
        end
      end
    end
  endgenerate

  // Head of the buffer; always a register, so the FIFO never sees ROM timing.
  assign output_V_din = rd_ptr_reg ? g_entry[1].data_reg : g_entry[0].data_reg;

  // ---------------------------------------------------------------------------
  // The issue rule guarantees a free slot for every returning read.
  // ---------------------------------------------------------------------------
  a_no_overflow : assert property (@(posedge ap_clk) disable iff (ap_rst)
                                   !(push && !pop && (count_reg == 2'd2)));

endmodule

// File: tb/tb_weight_rom_sequencer.sv
// -----------------------------------------------------------------------------
// tb_weight_rom_sequencer
//   Directed bench for weight_rom_sequencer. Two instances: dut_a with a 4-word
//   kernel and dut_b with a 288-word kernel, each fed by a behavioural
//   synchronous ROM. Inputs change 1 time unit after the rising edge; a
//   negative-edge monitor stamps ce, transfers and done pulses with the cycle
//   number so the directed cases can compare against hand-derived timelines.
// -----------------------------------------------------------------------------
module tb_weight_rom_sequencer;

  localparam int KA  = 4;
  localparam int KB  = 288;
  localparam int DW  = 16;
  localparam int PW  = 8;
  localparam int AWA = 2;
  localparam int AWB = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // dut_a (K=4)
  logic           start_a, done_a, idle_a, ce_a, full_n_a, write_a;
  logic [PW-1:0]  np_a;
  logic [AWA-1:0] addr_a;
  logic [DW-1:0]  q_a = '0;
  logic [DW-1:0]  din_a;
  // dut_b (K=288)
  logic           start_b, done_b, idle_b, ce_b, full_n_b, write_b;
  logic [PW-1:0]  np_b;
  logic [AWB-1:0] addr_b;
  logic [DW-1:0]  q_b = '0;
  logic [DW-1:0]  din_b;

  logic [DW-1:0] rom_a [KA];
  logic [DW-1:0] rom_b [KB];

  weight_rom_sequencer #(.KERN_SIZE(KA), .DATA_W(DW), .PASS_W(PW)) dut_a (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start_a), .num_passes(np_a),
    .ap_done(done_a), .ap_idle(idle_a), .weight_address(addr_a),
    .weight_ce(ce_a), .weight_q(q_a), .output_V_din(din_a),
    .output_V_full_n(full_n_a), .output_V_write(write_a)
  );

  weight_rom_sequencer #(.KERN_SIZE(KB), .DATA_W(DW), .PASS_W(PW)) dut_b (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start_b), .num_passes(np_b),
    .ap_done(done_b), .ap_idle(idle_b), .weight_address(addr_b),
    .weight_ce(ce_b), .weight_q(q_b), .output_V_din(din_b),
    .output_V_full_n(full_n_b), .output_V_write(write_b)
  );

  // Synchronous ROMs: data valid the cycle after ce.
  always @(posedge clk) if (ce_a) q_a <= rom_a[addr_a];
  always @(posedge clk) if (ce_b) q_b <= rom_b[addr_b];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor records
  int            ce_cyc_a[$];
  int            xf_cyc_a[$];
  logic [DW-1:0] xf_dat_a[$];
  int            done_cyc_a[$];
  int            xf_cnt_b;
  int            xf_bad_b;
  int            done_cnt_b;
  int            stall_viol;
  logic          stall_prev_a = 1'b0, stall_prev_b = 1'b0;
  logic [DW-1:0] stall_din_a, stall_din_b;

  always @(negedge clk) begin
    if (!rst) begin
      if (ce_a) ce_cyc_a.push_back(cyc);
      if (write_a && full_n_a) begin
        xf_cyc_a.push_back(cyc);
        xf_dat_a.push_back(din_a);
      end
      if (done_a) done_cyc_a.push_back(cyc);
      if (write_b && full_n_b) begin
        if (din_b !== rom_b[xf_cnt_b % KB]) xf_bad_b++;
        xf_cnt_b++;
      end
      if (done_b) done_cnt_b++;
      // Data must hold while the FIFO refuses it.
      if (write_a && !full_n_a) begin
        if (stall_prev_a && (din_a !== stall_din_a)) stall_viol++;
        stall_din_a  = din_a;
        stall_prev_a = 1'b1;
      end else begin
        stall_prev_a = 1'b0;
      end
      if (write_b && !full_n_b) begin
        if (stall_prev_b && (din_b !== stall_din_b)) stall_viol++;
        stall_din_b  = din_b;
        stall_prev_b = 1'b1;
      end else begin
        stall_prev_b = 1'b0;
      end
    end
  end

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_a();
    ce_cyc_a.delete();
    xf_cyc_a.delete();
    xf_dat_a.delete();
    done_cyc_a.delete();
  endtask

  task automatic wait_done_a(input int n, input int budget);
    for (int i = 0; i < budget && done_cyc_a.size() < n; i++) next_cycle();
    repeat (2) next_cycle();
  endtask

  // Transfers at s+first.. consecutive, data rom_a[i%4], n words.
  task automatic check_stream_a(input string tag, input int s, input int first, input int n);
    check({tag, "_xfer_count"}, xf_cyc_a.size(), n);
    for (int i = 0; i < n && i < xf_cyc_a.size(); i++) begin
      check($sformatf("%s_xfer%0d_cyc", tag, i), xf_cyc_a[i] - s, first + i);
      check($sformatf("%s_xfer%0d_dat", tag, i), xf_dat_a[i], 32'hA000 + (i % KA));
    end
  endtask

  int s;
  int exp_ce_t2 [4] = '{1, 2, 8, 9};

  initial begin
    for (int i = 0; i < KA; i++) rom_a[i] = DW'(16'hA000 + i);
    for (int i = 0; i < KB; i++) rom_b[i] = DW'(16'h5A00 + i * 37);
    rst = 1'b1;
    start_a = 1'b0; np_a = '0; full_n_a = 1'b1;
    start_b = 1'b0; np_b = '0; full_n_b = 1'b1;
    xf_cnt_b = 0; xf_bad_b = 0; done_cnt_b = 0; stall_viol = 0;
    stall_din_a = '0; stall_din_b = '0;
    repeat (2) next_cycle();

    // ---- Reset values --------------------------------------------------
    check("rst_idle", idle_a, 1);
    check("rst_done", done_a, 0);
    check("rst_ce", ce_a, 0);
    check("rst_addr", addr_a, 0);
    check("rst_write", write_a, 0);
    check("rst_din", din_a, 0);
    rst = 1'b0;
    next_cycle();

    // ---- T1: K=4, P=2, full_n=1 -----------------------------------------
    clear_a();
    start_a = 1'b1; np_a = 8'd2; full_n_a = 1'b1; s = cyc;
    next_cycle();
    start_a = 1'b0;
    check("t1_idle_low", idle_a, 0);
    wait_done_a(1, 100);
    check("t1_ce_count", ce_cyc_a.size(), 8);
    for (int i = 0; i < 8 && i < ce_cyc_a.size(); i++)
      check($sformatf("t1_ce%0d_cyc", i), ce_cyc_a[i] - s, 1 + i);
    check_stream_a("t1", s, 3, 8);
    check("t1_done_count", done_cyc_a.size(), 1);
    if (done_cyc_a.size() > 0) check("t1_done_cyc", done_cyc_a[0] - s, 11);

    // ---- T2: K=4, P=1, full_n low for cycles 3..7 -----------------------
    clear_a();
    stall_viol = 0;
    start_a = 1'b1; np_a = 8'd1; full_n_a = 1'b1; s = cyc;
    for (int k = 1; k <= 16; k++) begin
      next_cycle();
      start_a  = 1'b0;
      full_n_a = (k < 3 || k > 7);
      if (k == 5) begin
        check("t2_stall_write", write_a, 1);
        check("t2_stall_din", din_a, 32'hA000);
      end
    end
    full_n_a = 1'b1;
    wait_done_a(1, 50);
    check("t2_ce_count", ce_cyc_a.size(), 4);
    for (int i = 0; i < 4 && i < ce_cyc_a.size(); i++)
      check($sformatf("t2_ce%0d_cyc", i), ce_cyc_a[i] - s, exp_ce_t2[i]);
    check_stream_a("t2", s, 8, 4);
    check("t2_done_count", done_cyc_a.size(), 1);
    if (done_cyc_a.size() > 0) check("t2_done_cyc", done_cyc_a[0] - s, 12);
    check("t2_din_stable", stall_viol, 0);

    // ---- T3: num_passes=0 treated as 1 --------------------------------
    clear_a();
    start_a = 1'b1; np_a = 8'd0; s = cyc;
    next_cycle();
    start_a = 1'b0;
    wait_done_a(1, 50);
    check_stream_a("t3", s, 3, 4);
    check("t3_done_count", done_cyc_a.size(), 1);
    if (done_cyc_a.size() > 0) check("t3_done_cyc", done_cyc_a[0] - s, 7);

    // ---- T6: ap_start held high through DONE ---------------------------
    clear_a();
    start_a = 1'b1; np_a = 8'd1; s = cyc;
    for (int k = 1; k <= 9; k++) begin
      next_cycle();
      if (k == 7) check("t6_idle_in_done", idle_a, 0);
      if (k == 7) check("t6_done_pulse", done_a, 1);
      if (k == 8) check("t6_idle_between", idle_a, 1);
      if (k == 9) check("t6_second_ce", ce_a, 1);
    end
    start_a = 1'b0;
    wait_done_a(2, 50);
    check("t6_ce_count", ce_cyc_a.size(), 8);
    if (ce_cyc_a.size() >= 5) check("t6_ce4_cyc", ce_cyc_a[4] - s, 9);
    check("t6_xfer_count", xf_cyc_a.size(), 8);
    check("t6_done_count", done_cyc_a.size(), 2);
    if (done_cyc_a.size() >= 2) check("t6_done2_cyc", done_cyc_a[1] - s, 15);

    // ---- T4: K=288, P=3, random full_n ---------------------------------
    xf_cnt_b = 0; xf_bad_b = 0; done_cnt_b = 0; stall_viol = 0;
    start_b = 1'b1; np_b = 8'd3;
    next_cycle();
    start_b = 1'b0;
    for (int i = 0; i < 8000 && done_cnt_b == 0; i++) begin
      full_n_b = 1'($urandom_range(0, 1));
      next_cycle();
    end
    full_n_b = 1'b1;
    repeat (2) next_cycle();
    check("t4_done_seen", done_cnt_b, 1);
    check("t4_xfer_count", xf_cnt_b, 864);
    check("t4_data_errors", xf_bad_b, 0);
    check("t4_din_stable", stall_viol, 0);

    // ---- T5: reset mid-pass 1 at addr 100 ------------------------------
    start_b = 1'b1; np_b = 8'd2; full_n_b = 1'b1; s = cyc;
    next_cycle();
    start_b = 1'b0;
    check("t5_first_addr", addr_b, 0);
    repeat (388) next_cycle();
    check("t5_pre_rst_addr", addr_b, 100);
    check("t5_pre_rst_ce", ce_b, 1);
    rst = 1'b1;
    #1;
    check("t5_rst_idle", idle_b, 1);
    check("t5_rst_done", done_b, 0);
    check("t5_rst_ce", ce_b, 0);
    check("t5_rst_addr", addr_b, 0);
    check("t5_rst_write", write_b, 0);
    check("t5_rst_din", din_b, 0);
    next_cycle();
    rst = 1'b0;
    next_cycle();
    xf_cnt_b = 0; xf_bad_b = 0; done_cnt_b = 0;
    start_b = 1'b1; np_b = 8'd1;
    next_cycle();
    start_b = 1'b0;
    check("t5_restart_ce", ce_b, 1);
    check("t5_restart_addr", addr_b, 0);
    for (int i = 0; i < 1000 && done_cnt_b == 0; i++) next_cycle();
    repeat (2) next_cycle();
    check("t5_restart_done", done_cnt_b, 1);
    check("t5_restart_xfers", xf_cnt_b, KB);
    check("t5_restart_errors", xf_bad_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
